// File: rtl/multicycle_controller_if.sv
// Control/datapath/memory bundle for the multicycle controller.
// The controller is the master side; the datapath and memory sit on the slave side.
interface multicycle_controller_if #(
  parameter int COUNT_W = 32
);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               alu_zero;
  logic               mem_ready;
  logic               mem_req;
  logic               mem_we;
  logic               iord;
  logic               ir_we;
  logic               pc_we;
  logic [1:0]         pc_src;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [2:0]         alu_op;
  logic               tgt_we;
  logic               reg_we;
  logic [1:0]         reg_dst;
  logic [1:0]         mem_to_reg;
  logic [4:0]         ra_idx;
  logic               illegal;
  logic [2:0]         state;
  logic [COUNT_W-1:0] instr_cnt;
  logic [COUNT_W-1:0] stall_cnt;

  modport master (
    input  opcode, funct, alu_zero, mem_ready,
    output mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b, alu_op,
           tgt_we, reg_we, reg_dst, mem_to_reg, ra_idx, illegal, state, instr_cnt, stall_cnt
  );

  modport slave (
    output opcode, funct, alu_zero, mem_ready,
    input  mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b, alu_op,
           tgt_we, reg_we, reg_dst, mem_to_reg, ra_idx, illegal, state, instr_cnt, stall_cnt
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control FSM with sticky trap on unsupported encodings.
// Define CTRL_PERF_CNT_EN to build the retired-instruction and stall counters.
module multicycle_controller #(
  parameter int         COUNT_W = 32,
  parameter logic [4:0] RA_REG  = 5'd31
) (
  input logic                     clk,
  input logic                     rst_n,
  multicycle_controller_if.master bus
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t state_q, state_d;
  // run_q holds every output low until the first edge after reset release.
  logic   run_q;

  logic is_r, is_add, is_sub, is_slt, is_jr;
  logic is_lw, is_sw, is_addi, is_xori, is_bne, is_j, is_jal, is_legal;

  assign is_r     = (bus.opcode == OP_RTYPE);
  assign is_add   = is_r && (bus.funct == FN_ADD);
  assign is_sub   = is_r && (bus.funct == FN_SUB);
  assign is_slt   = is_r && (bus.funct == FN_SLT);
  assign is_jr    = is_r && (bus.funct == FN_JR);
  assign is_lw    = (bus.opcode == OP_LW);
  assign is_sw    = (bus.opcode == OP_SW);
  assign is_addi  = (bus.opcode == OP_ADDI);
  assign is_xori  = (bus.opcode == OP_XORI);
  assign is_bne   = (bus.opcode == OP_BNE);
  assign is_j     = (bus.opcode == OP_J);
  assign is_jal   = (bus.opcode == OP_JAL);
  assign is_legal = is_add || is_sub || is_slt || is_jr || is_lw || is_sw ||
                    is_addi || is_xori || is_bne || is_j || is_jal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (run_q) begin
      case (state_q)
        S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
        S_DECODE: begin
          if (!is_legal)                    state_d = S_TRAP;
          else if (is_j || is_jal || is_jr) state_d = S_FETCH;
          else                              state_d = S_EXEC;
        end
        S_EXEC: begin
          if (is_lw || is_sw) state_d = S_MEM;
          else if (is_bne)    state_d = S_FETCH;
          else                state_d = S_WB;
        end
        S_MEM:    if (bus.mem_ready) state_d = is_sw ? S_FETCH : S_WB;
        S_WB:     state_d = S_FETCH;
        S_TRAP:   state_d = S_TRAP;
        default:  state_d = S_TRAP;
      endcase
    end
  end

  always_comb begin
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.iord       = 1'b0;
    bus.ir_we      = 1'b0;
    bus.pc_we      = 1'b0;
    bus.pc_src     = 2'd0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'd0;
    bus.alu_op     = 3'd0;
    bus.tgt_we     = 1'b0;
    bus.reg_we     = 1'b0;
    bus.reg_dst    = 2'd0;
    bus.mem_to_reg = 2'd0;
    bus.ra_idx     = 5'd0;
    bus.illegal    = 1'b0;
    bus.state      = 3'd0;
    if (run_q) begin
      bus.ra_idx = RA_REG;
      bus.state  = state_q;
      case (state_q)
        S_FETCH: begin
          bus.mem_req = 1'b1;
          if (bus.mem_ready) begin
            bus.ir_we     = 1'b1;
            bus.pc_we     = 1'b1;
            bus.alu_src_b = 2'd1;
          end
        end
        S_DECODE: begin
          bus.alu_src_b = 2'd3;
          bus.tgt_we    = 1'b1;
          if (is_j || is_jal) begin
            bus.pc_we  = 1'b1;
            bus.pc_src = 2'd2;
          end
          if (is_jal) begin
            bus.reg_we     = 1'b1;
            bus.reg_dst    = 2'd2;
            bus.mem_to_reg = 2'd2;
          end
          if (is_jr) begin
            bus.pc_we  = 1'b1;
            bus.pc_src = 2'd3;
          end
        end
        S_EXEC: begin
          bus.alu_src_a = 1'b1;
          if (is_r) begin
            bus.alu_op = is_sub ? 3'd1 : (is_slt ? 3'd3 : 3'd0);
          end else if (is_bne) begin
            bus.alu_op = 3'd1;
            if (!bus.alu_zero) begin
              bus.pc_we  = 1'b1;
              bus.pc_src = 2'd1;
            end
          end else begin
            bus.alu_src_b = 2'd2;
            bus.alu_op    = is_xori ? 3'd2 : 3'd0;
          end
        end
        S_MEM: begin
          bus.mem_req = 1'b1;
          bus.iord    = 1'b1;
          bus.mem_we  = is_sw;
        end
        S_WB: begin
          bus.reg_we     = 1'b1;
          bus.reg_dst    = is_r ? 2'd1 : 2'd0;
          bus.mem_to_reg = is_lw ? 2'd1 : 2'd0;
        end
        S_TRAP:  bus.illegal = 1'b1;
        default: bus.illegal = 1'b0;
      endcase
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [COUNT_W-1:0] instr_cnt_q, stall_cnt_q;
  logic               retire;

  // A retire is any return to FETCH except from FETCH itself or from TRAP.
  assign retire = run_q && (state_q != S_FETCH) && (state_q != S_TRAP) && (state_d == S_FETCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (retire)                        instr_cnt_q <= instr_cnt_q + 1'b1;
      if (bus.mem_req && !bus.mem_ready) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.instr_cnt = instr_cnt_q;
  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.instr_cnt = {COUNT_W{1'b0}};
  assign bus.stall_cnt = {COUNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: per-instruction expected cycle sequences are queued by the driver
// and popped/compared by an independent negedge monitor.
module tb_multicycle_controller;
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       a;
    logic [1:0] b;
    logic [2:0] op;
    logic       tgt_we;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] m2r;
    logic [4:0] ra;
    logic       illegal;
    logic [2:0] state;
  } ctrl_t;

  typedef struct {
    ctrl_t c;
    logic  rdy;
    int    icnt;
    int    scnt;
  } exp_t;

  localparam int K_ILL = 0, K_ADD = 1, K_SUB = 2, K_SLT = 3, K_JR = 4, K_LW = 5, K_SW = 6;
  localparam int K_ADDI = 7, K_XORI = 8, K_BNE = 9, K_J = 10, K_JAL = 11;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   m_icnt;
  int   m_scnt;
  exp_t plan[$];
  exp_t exp_q[$];
  logic [5:0] lop[11];
  logic [5:0] lfn[11];

  multicycle_controller_if #(.COUNT_W(32)) bus ();

  multicycle_controller #(.COUNT_W(32), .RA_REG(5'd31)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit expired, queue=%0d", exp_q.size());
    $fatal(1);
  end

  function automatic ctrl_t sample();
    ctrl_t s;
    s.mem_req = bus.mem_req;   s.mem_we = bus.mem_we;   s.iord = bus.iord;
    s.ir_we   = bus.ir_we;     s.pc_we  = bus.pc_we;    s.pc_src = bus.pc_src;
    s.a       = bus.alu_src_a; s.b      = bus.alu_src_b; s.op    = bus.alu_op;
    s.tgt_we  = bus.tgt_we;    s.reg_we = bus.reg_we;   s.reg_dst = bus.reg_dst;
    s.m2r     = bus.mem_to_reg; s.ra    = bus.ra_idx;   s.illegal = bus.illegal;
    s.state   = bus.state;
    return s;
  endfunction

  function automatic int kind_of(logic [5:0] op, logic [5:0] fn);
    case (op)
      6'b000000: case (fn)
        6'b100000: return K_ADD;
        6'b100010: return K_SUB;
        6'b101010: return K_SLT;
        6'b001000: return K_JR;
        default:   return K_ILL;
      endcase
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b001000: return K_ADDI;
      6'b001110: return K_XORI;
      6'b000101: return K_BNE;
      6'b000010: return K_J;
      6'b000011: return K_JAL;
      default:   return K_ILL;
    endcase
  endfunction

  task automatic add(input ctrl_t c, input logic rdy);
    exp_t e;
    c.ra   = 5'd31;
    e.c    = c;
    e.rdy  = rdy;
    e.icnt = m_icnt;
    e.scnt = m_scnt;
    if (c.mem_req && !rdy) m_scnt++;
    plan.push_back(e);
  endtask

  // Expected cycle-by-cycle behaviour of one instruction, straight from the opcode's rules.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                       input int fs, input int ms, input int ntrap);
    ctrl_t c;
    int    k;
    k = kind_of(op, fn);
    for (int i = 0; i < fs; i++) begin
      c = '0; c.mem_req = 1; add(c, 1'b0);
    end
    c = '0; c.mem_req = 1; c.ir_we = 1; c.pc_we = 1; c.b = 2'd1; add(c, 1'b1);
    c = '0; c.state = 3'd1; c.b = 2'd3; c.tgt_we = 1;
    if (k == K_J || k == K_JAL) begin c.pc_we = 1; c.pc_src = 2'd2; end
    if (k == K_JAL) begin c.reg_we = 1; c.reg_dst = 2'd2; c.m2r = 2'd2; end
    if (k == K_JR) begin c.pc_we = 1; c.pc_src = 2'd3; end
    add(c, 1'($urandom_range(0, 1)));
    if (k == K_ILL) begin
      for (int i = 0; i < ntrap; i++) begin
        c = '0; c.illegal = 1; c.state = 3'd5; add(c, 1'($urandom_range(0, 1)));
      end
      return;
    end
    if (k == K_J || k == K_JAL || k == K_JR) begin m_icnt++; return; end
    c = '0; c.state = 3'd2; c.a = 1;
    case (k)
      K_SUB:  c.op = 3'd1;
      K_SLT:  c.op = 3'd3;
      K_XORI: begin c.b = 2'd2; c.op = 3'd2; end
      K_ADDI, K_LW, K_SW: c.b = 2'd2;
      K_BNE: begin c.op = 3'd1; if (!zero) begin c.pc_we = 1; c.pc_src = 2'd1; end end
      default: c.op = 3'd0;
    endcase
    add(c, 1'($urandom_range(0, 1)));
    if (k == K_BNE) begin m_icnt++; return; end
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i <= ms; i++) begin
        c = '0; c.state = 3'd3; c.mem_req = 1; c.iord = 1; c.mem_we = (k == K_SW);
        add(c, (i == ms));
      end
      if (k == K_SW) begin m_icnt++; return; end
    end
    c = '0; c.state = 3'd4; c.reg_we = 1;
    c.reg_dst = (k == K_LW) ? 2'd0 : ((k == K_ADDI || k == K_XORI) ? 2'd0 : 2'd1);
    c.m2r = (k == K_LW) ? 2'd1 : 2'd0;
    add(c, 1'($urandom_range(0, 1)));
    m_icnt++;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                           input int fs, input int ms, input int ntrap, input int max_cyc);
    @(posedge clk); #1;
    plan.delete();
    build(op, fn, zero, fs, ms, ntrap);
    if (max_cyc > 0 && plan.size() > max_cyc) begin
      while (plan.size() > max_cyc) void'(plan.pop_back());
    end
    foreach (plan[i]) exp_q.push_back(plan[i]);
    bus.opcode   = op;
    bus.funct    = fn;
    bus.alu_zero = zero;
    for (int i = 0; i < plan.size(); i++) begin
      bus.mem_ready = plan[i].rdy;
      if (i + 1 < plan.size()) begin @(posedge clk); #1; end
    end
  endtask

  task automatic rand_instr();
    int idx;
    idx = $urandom_range(0, 10);
    run_instr(lop[idx], lfn[idx], 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0,
              $urandom_range(0, 3), 0, 0);
  endtask

  task automatic check_idle(input string name);
    vectors++;
    if (sample() !== ctrl_t'(0)) begin
      miscompares++;
      $display("FAIL %s outputs: got %h, want 0", name, sample());
    end
    vectors++;
    if (bus.instr_cnt !== 32'd0 || bus.stall_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL %s counters: got instr=%0d stall=%0d, want 0", name, bus.instr_cnt, bus.stall_cnt);
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge clk); #2;
    rst_n = 1'b0;
    bus.mem_ready = 1'b0;
    #1 check_idle(name);
    @(posedge clk); #3;
    rst_n = 1'b1;
    #1 check_idle({name, "_release"});
    m_icnt = 0;
    m_scnt = 0;
  endtask

  always @(negedge clk) begin
    exp_t  e;
    ctrl_t act;
    int    ei, es;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = sample();
      vectors++;
      if (act !== e.c) begin
        miscompares++;
        $display("FAIL ctrl op=%b fn=%b: got %h, want %h", bus.opcode, bus.funct, act, e.c);
      end
`ifdef CTRL_PERF_CNT_EN
      ei = e.icnt;
      es = e.scnt;
`else
      ei = 0;
      es = 0;
`endif
      vectors++;
      if (bus.instr_cnt !== 32'(ei) || bus.stall_cnt !== 32'(es)) begin
        miscompares++;
        $display("FAIL counters: got instr=%0d stall=%0d, want instr=%0d stall=%0d",
                 bus.instr_cnt, bus.stall_cnt, ei, es);
      end
    end
  end

  initial begin
    lop = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h23, 6'h2b, 6'h08, 6'h0e, 6'h05, 6'h02, 6'h03};
    lfn = '{6'h20, 6'h22, 6'h2a, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    vectors = 0;
    miscompares = 0;
    m_icnt = 0;
    m_scnt = 0;
    rst_n = 1'b0;
    bus.opcode = 6'h00;
    bus.funct = 6'h00;
    bus.alu_zero = 1'b0;
    bus.mem_ready = 1'b0;
    #2 check_idle("reset");
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b1;
    #1 check_idle("release");

    run_instr(6'h00, 6'h20, 1'b0, 0, 0, 0, 0);
    run_instr(6'h23, 6'h00, 1'b0, 0, 3, 0, 0);
    run_instr(6'h05, 6'h00, 1'b1, 0, 0, 0, 0);
    run_instr(6'h05, 6'h00, 1'b0, 1, 0, 0, 0);
    run_instr(6'h03, 6'h00, 1'b0, 0, 0, 0, 0);
    run_instr(6'h2b, 6'h00, 1'b0, 2, 2, 0, 0);
    for (int n = 0; n < 60; n++) rand_instr();

    run_instr(6'h3f, 6'h00, 1'b0, 0, 0, 10, 0);
    do_reset("trap_op");
    rand_instr();
    run_instr(6'h00, 6'h3f, 1'b0, 1, 0, 4, 0);
    do_reset("trap_funct");
    rand_instr();
    run_instr(6'h23, 6'h00, 1'b0, 0, 20, 0, 5);
    do_reset("mid_mem");
    for (int n = 0; n < 10; n++) rand_instr();

    @(posedge clk); #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
